// File: rtl/deser_stack_arbiter.sv
// Round-robin arbiter moving words from two deserializer channels onto a stack.
// Optional ready synchronizers are enabled with macro DESER_STACK_ARBITER_SYNC_EN.
//
// state      | meaning
// S_IDLE     | sample full/empty, serve pops first, otherwise grant a ready channel
// S_PUSH     | one-cycle push strobe, granted ack rises
// S_ACK_WAIT | hold ack until the granted ready falls, then count the transfer
module deser_stack_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic       rdy0_in,
  input  logic [7:0] data0_in,
  output logic       ack0_out,
  input  logic       rdy1_in,
  input  logic [7:0] data1_in,
  output logic       ack1_out,
  output logic       push_out,
  output logic [7:0] push_data_out,
  input  logic       full_in,
  input  logic       pop_req_in,
  input  logic       empty_in,
  output logic       pop_out,
  output logic       grant_out,
  output logic       busy_out,
  output logic [7:0] xfer_count_out
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_PUSH     = 2'd1;
  localparam logic [1:0] S_ACK_WAIT = 2'd2;

  logic [1:0] r_state;
  logic       r_grant;
  logic       r_last;
  logic [7:0] r_push_data;
  logic       r_pop;
  logic [7:0] r_xfer_count;

  logic w_rdy0;
  logic w_rdy1;
  logic w_pop_go;
  logic w_grant_go;
  logic w_sel;
  logic w_granted_rdy;
  logic w_active;

`ifdef DESER_STACK_ARBITER_SYNC_EN
  logic [1:0] r_rdy0_sync;
  logic [1:0] r_rdy1_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdy0_sync <= 2'b00;
      r_rdy1_sync <= 2'b00;
    end else begin
      r_rdy0_sync <= {r_rdy0_sync[0], rdy0_in};
      r_rdy1_sync <= {r_rdy1_sync[0], rdy1_in};
    end
  end

  assign w_rdy0 = r_rdy0_sync[1];
  assign w_rdy1 = r_rdy1_sync[1];
`else
  assign w_rdy0 = rdy0_in;
  assign w_rdy1 = rdy1_in;
`endif

  assign w_pop_go      = (r_state == S_IDLE) && pop_req_in && !empty_in;
  assign w_grant_go    = (r_state == S_IDLE) && !w_pop_go && !full_in && (w_rdy0 || w_rdy1);
  // With both ready the channel not served last wins; r_last resets to 1 so channel 0 goes first.
  assign w_sel         = (w_rdy0 && w_rdy1) ? ~r_last : w_rdy1;
  assign w_granted_rdy = r_grant ? w_rdy1 : w_rdy0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_grant      <= 1'b0;
      r_last       <= 1'b1;
      r_push_data  <= 8'h00;
      r_pop        <= 1'b0;
      r_xfer_count <= 8'h00;
    end else begin
      r_pop <= w_pop_go;
      case (r_state)
        S_IDLE: begin
          if (w_grant_go) begin
            r_state     <= S_PUSH;
            r_grant     <= w_sel;
            r_last      <= w_sel;
            r_push_data <= w_sel ? data1_in : data0_in;
          end
        end
        S_PUSH: r_state <= S_ACK_WAIT;
        S_ACK_WAIT: begin
          if (!w_granted_rdy) begin
            r_state      <= S_IDLE;
            r_xfer_count <= r_xfer_count + 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_active       = (r_state == S_PUSH) || (r_state == S_ACK_WAIT);
  assign push_out       = (r_state == S_PUSH);
  assign ack0_out       = w_active && !r_grant;
  assign ack1_out       = w_active && r_grant;
  assign busy_out       = w_active;
  assign pop_out        = r_pop;
  assign grant_out      = r_grant;
  assign push_data_out  = r_push_data;
  assign xfer_count_out = r_xfer_count;

endmodule

// File: tb/tb_deser_stack_arbiter.sv
// Directed bench for deser_stack_arbiter; latency expectations follow
// DESER_STACK_ARBITER_SYNC_EN when it is defined for the build.
module tb_deser_stack_arbiter;

`ifdef DESER_STACK_ARBITER_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk;
  logic       reset;
  logic       rdy0_in;
  logic [7:0] data0_in;
  logic       ack0_out;
  logic       rdy1_in;
  logic [7:0] data1_in;
  logic       ack1_out;
  logic       push_out;
  logic [7:0] push_data_out;
  logic       full_in;
  logic       pop_req_in;
  logic       empty_in;
  logic       pop_out;
  logic       grant_out;
  logic       busy_out;
  logic [7:0] xfer_count_out;

  int nerr = 0;
  int nchk = 0;
  int viol = 0;

  deser_stack_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .rdy0_in        (rdy0_in),
    .data0_in       (data0_in),
    .ack0_out       (ack0_out),
    .rdy1_in        (rdy1_in),
    .data1_in       (data1_in),
    .ack1_out       (ack1_out),
    .push_out       (push_out),
    .push_data_out  (push_data_out),
    .full_in        (full_in),
    .pop_req_in     (pop_req_in),
    .empty_in       (empty_in),
    .pop_out        (pop_out),
    .grant_out      (grant_out),
    .busy_out       (busy_out),
    .xfer_count_out (xfer_count_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Structural invariants watched on every falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (push_out && pop_out) viol++;
      if (ack0_out && ack1_out) viol++;
      if (busy_out !== (ack0_out | ack1_out)) viol++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_push(output int n);
    n = 0;
    while (!push_out && n < 40) begin
      step();
      n++;
    end
  endtask

  // Called in the PUSH cycle: completes the 4-phase handshake on channel ch.
  task automatic finish_xfer(input int ch);
    int k;
    step();
    if (ch == 0) rdy0_in = 1'b0;
    else         rdy1_in = 1'b0;
    k = 0;
    while (busy_out && k < 40) begin
      step();
      k++;
    end
    check("handshake_done", busy_out, 1'b0);
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    rdy0_in = 1'b0;
    rdy1_in = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    int n;
    int c;
    logic seen;

    reset = 1'b1; rdy0_in = 1'b0; rdy1_in = 1'b0; data0_in = 8'h00; data1_in = 8'h00;
    full_in = 1'b0; pop_req_in = 1'b0; empty_in = 1'b1;
    step();
    check("rst_push", push_out, 1'b0);
    check("rst_ack", {ack1_out, ack0_out}, 2'b00);
    check("rst_busy", busy_out, 1'b0);
    check("rst_grant", grant_out, 1'b0);
    check("rst_count", xfer_count_out, 8'h00);
    check("rst_pop", pop_out, 1'b0);
    step();
    reset = 1'b0;

    // Single transfer on channel 0
    rdy0_in = 1'b1; data0_in = 8'hA5;
    wait_push(n);
    check("single_latency", n, 1 + LAT);
    check("single_data", push_data_out, 8'hA5);
    check("single_ack", {ack1_out, ack0_out}, 2'b01);
    check("single_grant", grant_out, 1'b0);
    c = 1;
    step();
    check("single_push_1cyc", push_out, 1'b0);
    rdy0_in = 1'b0;
    while (ack0_out && c < 20) begin
      c++;
      step();
    end
    check("single_ack_cycles", c, 2 + LAT);
    check("single_count", xfer_count_out, 8'd1);
    check("single_idle", busy_out, 1'b0);

    // Contention after reset: channel 0 first, then channel 1
    do_reset();
    rdy0_in = 1'b1; rdy1_in = 1'b1; data0_in = 8'h11; data1_in = 8'h22;
    wait_push(n);
    check("cont1_latency", n, 1 + LAT);
    check("cont1_data", push_data_out, 8'h11);
    check("cont1_grant", grant_out, 1'b0);
    finish_xfer(0);
    wait_push(n);
    check("cont2_latency", n, 1);
    check("cont2_data", push_data_out, 8'h22);
    check("cont2_grant", grant_out, 1'b1);
    check("cont2_ack", {ack1_out, ack0_out}, 2'b10);
    finish_xfer(1);
    rdy0_in = 1'b1; data0_in = 8'h33;
    wait_push(n);
    check("cont3_data", push_data_out, 8'h33);
    finish_xfer(0);
    // Channel 0 granted last: channel 1 must win the next tie
    rdy0_in = 1'b1; rdy1_in = 1'b1; data0_in = 8'h55; data1_in = 8'h66;
    wait_push(n);
    check("cont4_latency", n, 1 + LAT);
    check("cont4_data", push_data_out, 8'h66);
    check("cont4_grant", grant_out, 1'b1);
    finish_xfer(1);
    wait_push(n);
    check("cont5_data", push_data_out, 8'h55);
    check("cont5_grant", grant_out, 1'b0);
    finish_xfer(0);
    check("cont_count", xfer_count_out, 8'd5);

    // Stack full holds off the grant
    full_in = 1'b1; rdy1_in = 1'b1; data1_in = 8'h77;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      seen = seen | push_out | ack1_out;
    end
    check("full_no_grant", seen, 1'b0);
    full_in = 1'b0;
    wait_push(n);
    check("full_release_latency", n, 1);
    check("full_data", push_data_out, 8'h77);
    full_in = 1'b1;
    step();
    check("full_in_push_keeps_ack", ack1_out, 1'b1);
    rdy1_in = 1'b0;
    c = 0;
    while (busy_out && c < 40) begin
      step();
      c++;
    end
    full_in = 1'b0;
    check("full_count", xfer_count_out, 8'd6);

    // Pop beats push in the same IDLE cycle
    full_in = 1'b1; rdy0_in = 1'b1; data0_in = 8'h88;
    step(); step(); step();
    full_in = 1'b0; pop_req_in = 1'b1; empty_in = 1'b0;
    step();
    check("pop_first", pop_out, 1'b1);
    check("pop_no_push", push_out, 1'b0);
    pop_req_in = 1'b0;
    step();
    check("pop_then_push", push_out, 1'b1);
    check("pop_pulse_1cyc", pop_out, 1'b0);
    check("pop_push_data", push_data_out, 8'h88);
    finish_xfer(0);
    pop_req_in = 1'b1; empty_in = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      seen = seen | pop_out;
    end
    check("pop_empty_blocked", seen, 1'b0);
    pop_req_in = 1'b0;
    check("pop_count", xfer_count_out, 8'd7);

    // Reset while waiting for ready to fall
    rdy0_in = 1'b1; data0_in = 8'h99;
    wait_push(n);
    step();
    check("ackwait_busy", busy_out, 1'b1);
    reset = 1'b1;
    #1;
    check("mid_rst_ack", {ack1_out, ack0_out}, 2'b00);
    check("mid_rst_busy", busy_out, 1'b0);
    check("mid_rst_count", xfer_count_out, 8'h00);
    check("mid_rst_data", push_data_out, 8'h00);
    step();
    reset = 1'b0;
    wait_push(n);
    check("rearb_latency", n, 1 + LAT);
    check("rearb_data", push_data_out, 8'h99);
    check("rearb_grant", grant_out, 1'b0);
    finish_xfer(0);
    check("rearb_count", xfer_count_out, 8'd1);

    // Counter wrap
    for (int i = 0; i < 254; i++) begin
      rdy0_in = 1'b1; data0_in = i[7:0];
      wait_push(n);
      finish_xfer(0);
    end
    check("count_255", xfer_count_out, 8'd255);
    rdy0_in = 1'b1;
    wait_push(n);
    finish_xfer(0);
    check("count_wrap", xfer_count_out, 8'd0);

    check("invariants", viol, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
